// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator and frame-store display reader, with swaps
// of the double buffer deferred to the start of vertical blanking.
module vga_scanout #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   PIXEL_W     = 24
) (
    input  logic               clock,
    input  logic               reset,
    output logic [9:0]         address_x,
    output logic [9:0]         address_y,
    input  logic [PIXEL_W-1:0] pixel_data,
    input  logic               swap_request,
    output logic               switch_buffer,
    output logic               swap_pending,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [PIXEL_W-1:0] rgb
);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic {IDLE, PENDING} state_t;

    logic [9:0]         h_q, h_d, v_q, v_d;
    logic               vis, hs, vs, swap_point;
    logic               active_q, active_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic [PIXEL_W-1:0] rgb_q, rgb_d;
    state_t             state_q, state_d;

    always_comb begin
        h_d        = (h_q == H_LAST) ? '0 : h_q + 10'd1;
        v_d        = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 10'd1;
        vis        = (h_q < H_VIS) && (v_q < V_VIS);
        hs         = (h_q >= HS_BEG) && (h_q < HS_END);
        vs         = (v_q >= VS_BEG) && (v_q < VS_END);
        swap_point = (h_q == '0) && (v_q == V_VIS);
        active_d   = vis;
        rgb_d      = vis ? pixel_data : '0;
        hsync_d    = hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d    = vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_q      <= '0;
            v_q      <= '0;
            active_q <= 1'b0;
            rgb_q    <= '0;
            hsync_q  <= ~SYNC_ACTIVE;
            vsync_q  <= ~SYNC_ACTIVE;
            state_q  <= IDLE;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            active_q <= active_d;
            rgb_q    <= rgb_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            state_q  <= state_d;
        end
    end

    // A request landing on the swap point is served at once and never parks in PENDING.
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = (swap_request && !swap_point) ? PENDING : IDLE;
        else
            state_d = swap_point ? IDLE : PENDING;
    end

    always_comb begin
        swap_pending  = (state_q == PENDING);
        switch_buffer = swap_point && ((state_q == PENDING) || swap_request);
    end

    // Reset holds the counters at (0,0), so frame_start is masked while reset is high.
    assign frame_start = ~reset && (h_q == '0) && (v_q == '0);
    assign address_x   = vis ? h_q : '0;
    assign address_y   = vis ? v_q : '0;
    assign active      = active_q;
    assign rgb         = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout using shrunken timing so
// every frame-level scenario fits in a few thousand cycles.
module tb_vga_scanout;
    localparam int HA = 16, HF = 4, HS = 6, HB = 4;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic        act;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } out_t;

    logic        clock = 1'b0, reset = 1'b0, swap_request = 1'b0;
    logic [9:0]  address_x, address_y;
    logic [23:0] pixel_data, rgb;
    logic        switch_buffer, swap_pending, frame_start, hsync, vsync, active;

    int   checks = 0, errors = 0;
    int   mx = 0, my = 0;
    int   pulses = 0, px = -1, py = -1;
    out_t sb[$];

    always #5 clock = ~clock;

    // Memory stand-in: each pixel's value is its own {y, x} address.
    assign pixel_data = {4'h0, address_y, address_x};

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE(1'b0), .PIXEL_W(24)
    ) dut (
        .clock(clock), .reset(reset),
        .address_x(address_x), .address_y(address_y),
        .pixel_data(pixel_data), .swap_request(swap_request),
        .switch_buffer(switch_buffer), .swap_pending(swap_pending),
        .frame_start(frame_start), .hsync(hsync), .vsync(vsync),
        .active(active), .rgb(rgb)
    );

    function automatic out_t exp_out(input int x, input int y);
        logic v;
        v = (x < HA) && (y < VA);
        exp_out.act = v;
        exp_out.hs  = !((x >= HA + HF) && (x < HA + HF + HS));
        exp_out.vs  = !((y >= VA + VF) && (y < VA + VF + VS));
        exp_out.rgb = v ? {4'h0, 10'(y), 10'(x)} : 24'h0;
    endfunction

    task automatic step();
        @(posedge clock);
        if (mx == HT - 1) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end else mx++;
        @(negedge clock);
    endtask

    task automatic goto(input int x, input int y);
        int n;
        n = 0;
        while (!(mx == x && my == y) && n < HT * VT) begin
            if (switch_buffer) begin
                pulses++;
                px = mx;
                py = my;
            end
            step();
            n++;
        end
    endtask

    task automatic req();
        swap_request = 1'b1;
        step();
        swap_request = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({active, rgb, hsync, vsync, switch_buffer, swap_pending, frame_start} !== {1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s: active=%b rgb=%h hs=%b vs=%b sw=%b pend=%b fs=%b, want 0 000000 1 1 0 0 0",
                     tag, active, rgb, hsync, vsync, switch_buffer, swap_pending, frame_start);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_values("reset_values");
        reset = 1'b0;
        mx = 0;
        my = 0;
        #1;
        checks++;
        if ({frame_start, address_x, address_y} !== {1'b1, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL first_cycle: fs=%b addr=(%0d,%0d), want 1 (0,0)", frame_start, address_x, address_y);
        end
    endtask

    task automatic test_frame_timing();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 2 * HT * VT);
        checks++;
        if (n !== HT * VT) begin
            errors++;
            $display("FAIL frame_period: got %0d cycles, want %0d", n, HT * VT);
        end
    endtask

    task automatic test_pixels();
        out_t obs, e;
        int bad_addr, bad_fs;
        bad_addr = 0;
        bad_fs = 0;
        sb.delete();
        for (int i = 0; i <= HT * VT; i++) begin
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                obs = {active, hsync, vsync, rgb};
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL pixel_out at (%0d,%0d): act/hs/vs/rgb=%b%b%b %h, want %b%b%b %h",
                             mx, my, obs.act, obs.hs, obs.vs, obs.rgb, e.act, e.hs, e.vs, e.rgb);
                end
            end
            sb.push_back(exp_out(mx, my));
            if ({address_x, address_y} !== ((mx < HA && my < VA) ? {10'(mx), 10'(my)} : 20'h0)) bad_addr++;
            if (frame_start !== (mx == 0 && my == 0)) bad_fs++;
            if (i < HT * VT) step();
        end
        sb.delete();
        checks++;
        if (bad_addr != 0) begin
            errors++;
            $display("FAIL address: %0d bad cycles, want 0", bad_addr);
        end
        checks++;
        if (bad_fs != 0) begin
            errors++;
            $display("FAIL frame_start_pos: %0d bad cycles, want 0", bad_fs);
        end
    endtask

    task automatic test_swap_single();
        goto(5, 6);
        pulses = 0;
        req();
        checks++;
        if (swap_pending !== 1'b1) begin
            errors++;
            $display("FAIL single_pending: got %b, want 1", swap_pending);
        end
        goto(0, VA);
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL single_early: %0d pulses before swap point, want 0", pulses);
        end
        checks++;
        if ({switch_buffer, swap_pending} !== 2'b11) begin
            errors++;
            $display("FAIL single_pulse: sw/pend=%b%b, want 11", switch_buffer, swap_pending);
        end
        step();
        checks++;
        if ({switch_buffer, swap_pending} !== 2'b00) begin
            errors++;
            $display("FAIL single_after: sw/pend=%b%b, want 00", switch_buffer, swap_pending);
        end
        pulses = 0;
        goto(0, 0);
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL single_extra: %0d extra pulses, want 0", pulses);
        end
    endtask

    task automatic test_swap_multi();
        pulses = 0;
        px = -1;
        py = -1;
        goto(2, 1);
        req();
        goto(8, 3);
        req();
        goto(3, 9);
        req();
        goto(0, 0);
        checks++;
        if (pulses != 1 || px != 0 || py != VA) begin
            errors++;
            $display("FAIL multi: %0d pulses last at (%0d,%0d), want 1 at (0,%0d)", pulses, px, py, VA);
        end
    endtask

    task automatic test_swap_coincident();
        goto(0, VA);
        swap_request = 1'b1;
        #1;
        checks++;
        if ({switch_buffer, swap_pending} !== 2'b10) begin
            errors++;
            $display("FAIL coincident_pulse: sw/pend=%b%b, want 10", switch_buffer, swap_pending);
        end
        step();
        swap_request = 1'b0;
        checks++;
        if ({switch_buffer, swap_pending} !== 2'b00) begin
            errors++;
            $display("FAIL coincident_after: sw/pend=%b%b, want 00", switch_buffer, swap_pending);
        end
        pulses = 0;
        goto(0, 0);
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL coincident_extra: %0d pulses, want 0", pulses);
        end
    endtask

    task automatic test_reset_midframe();
        goto(3, 2);
        req();
        goto(12, 8);
        checks++;
        if (swap_pending !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pending: got %b, want 1", swap_pending);
        end
        reset = 1'b1;
        #1;
        check_reset_values("midframe_reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        mx = 0;
        my = 0;
        #1;
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL midframe_restart: fs=%b, want 1", frame_start);
        end
        pulses = 0;
        goto(0, VA + 1);
        goto(0, 0);
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midframe_discard: %0d pulses, want 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_pixels();
        test_swap_single();
        test_swap_multi();
        test_swap_coincident();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display-side consumer of the double-buffered frame store: generates 640x480@60 VGA timing from the pixel clock, drives the read-only display port (x/y address) of the buffer mux, aligns the returned pixel with sync, and outputs RGB and sync to the DAC/HDMI encoder. It also owns buffer-swap timing: a renderer's swap request is deferred and issued as a single `switch_buffer` pulse at the start of vertical blanking, so a swap never tears a visible frame.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width
- `V_BP`, 33, vertical back porch
- `SYNC_ACTIVE`, 1'b0, asserted level of hsync/vsync

Ports (reset `reset`, asynchronous, active-high; clock `clock`):
- `clock`  in  1  pixel clock
- `reset`  in  1  async active-high reset
- `address_x`  out  10  display-port x address to buffer mux
- `address_y`  out  10  display-port y address to buffer mux
- `pixel_data`  in  pixel_t  display-port read data (valid same cycle as address)
- `swap_request`  in  1  one-cycle pulse from renderer: back buffer complete
- `switch_buffer`  out  1  one-cycle pulse to buffer mux
- `swap_pending`  out  1  request accepted, swap not yet issued
- `frame_start`  out  1  one-cycle pulse at h=0, v=0 (counter stage)
- `hsync`, `vsync`  out  1  sync outputs (output stage)
- `active`  out  1  output pixel is visible
- `rgb`  out  pixel_t  output pixel; 0 when not active

## Operation
- `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (800), `V_TOTAL` (525); counters `h_count`, `v_count` 10 bits unsigned.
- `h_count` increments every clock, wraps `H_TOTAL-1 -> 0`; on that wrap `v_count` increments, wraps `V_TOTAL-1 -> 0`.
- Counter-stage signals: `vis = h_count<H_ACTIVE && v_count<V_ACTIVE`; `hs = h_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)`; `vs = v_count in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)`.
- `address_x = vis ? h_count : 0`; `address_y = vis ? v_count : 0` (combinational from counters).
- Output stage (registered): `active <= vis`; `rgb <= vis ? pixel_data : 0`; `hsync <= hs ? SYNC_ACTIVE : ~SYNC_ACTIVE`; same for `vsync`.
- Swap FSM, states IDLE / PENDING:
  - IDLE + `swap_request` -> PENDING.
  - PENDING + swap point -> IDLE, `switch_buffer` = 1 for that one cycle.
  - Swap point: `h_count==0 && v_count==V_ACTIVE` (first blanking line).
  - `swap_request` on the swap point cycle while IDLE: swap issued that same cycle, state stays IDLE.
  - `swap_request` while PENDING: absorbed; still exactly one pulse.
  - `swap_pending` = (state==PENDING).
- `switch_buffer` is a registered/decoded pulse never longer than one cycle; at most one per frame.

## Timing
- Reset values: counters 0, `active`=0, `rgb`=0, `hsync`=`vsync`=`~SYNC_ACTIVE`, `switch_buffer`=0, `swap_pending`=0, `frame_start`=0, state IDLE.
- First cycle after reset release: counters at (0,0), `frame_start`=1, address (0,0).
- Pixel latency: address for (x,y) in cycle N -> `rgb`=pixel(x,y) with `active`=1 in cycle N+1; sync outputs delayed identically so alignment is exact.
- Reset mid-frame: everything returns to reset values immediately; pending swap discarded.
- Swap takes effect at the buffer mux on the clock edge ending the pulse cycle; first pixel from new buffer is (0,0) of the next frame, 45 lines later.

## Test plan
- Reset release -> `frame_start` at cycle 0; next `frame_start` exactly 800*525 = 420000 cycles later; hsync low for 96 clocks starting h=656; vsync low for lines 490-491.
- Drive `pixel_data = {address_y, address_x}` pattern -> `rgb` at cycle N+1 equals address of cycle N for all visible pixels; `rgb`=0 and `active`=0 at h=640..799 and lines 480..524.
- `swap_request` pulse at (h=100, v=200) -> `swap_pending`=1 next cycle; `switch_buffer`=1 exactly at (0,480), `swap_pending`=0 after; no other pulse that frame.
- Three `swap_request` pulses in one frame -> exactly one `switch_buffer` pulse at (0,480).
- `swap_request` coincident with (0,480) while IDLE -> `switch_buffer`=1 same cycle, `swap_pending` stays 0.
- Assert `reset` at (300,250) with swap pending -> all outputs at reset values asynchronously; after release no `switch_buffer` until a new request.
